// File: rtl/baggage_drop_pkg.sv
// Package shared by the baggage-drop timing slice.
//   DEF_SENS_W / DEF_TIME_W / DEF_SCALE : default widths and height-to-radicand factor
//   SQRT_ITER                           : square-root iterations (one result bit each)
//   state_t                             : drop_time_calc FSM states (2-bit)
package baggage_drop_pkg;

  localparam int unsigned DEF_SENS_W = 8;
  localparam int unsigned DEF_TIME_W = 16;
  localparam int unsigned DEF_SCALE  = 400;
  localparam int unsigned SQRT_ITER  = DEF_TIME_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ROOT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/drop_time_calc_if.sv
// Measurement request / result bundle for drop_time_calc.
//   master : drives start, sensor1..4, t_lim_in; observes busy, done, t_act, t_lim, drop_en
//   slave  : the calculator side (directions reversed)
interface drop_time_calc_if
  import baggage_drop_pkg::*;
#(
  parameter int unsigned SENS_W = DEF_SENS_W,
  parameter int unsigned TIME_W = DEF_TIME_W
);

  logic              start;
  logic [SENS_W-1:0] sensor1;
  logic [SENS_W-1:0] sensor2;
  logic [SENS_W-1:0] sensor3;
  logic [SENS_W-1:0] sensor4;
  logic [TIME_W-1:0] t_lim_in;
  logic              busy;
  logic              done;
  logic [TIME_W-1:0] t_act;
  logic [TIME_W-1:0] t_lim;
  logic              drop_en;

  modport master (
    output start, sensor1, sensor2, sensor3, sensor4, t_lim_in,
    input  busy, done, t_act, t_lim, drop_en
  );

  modport slave (
    input  start, sensor1, sensor2, sensor3, sensor4, t_lim_in,
    output busy, done, t_act, t_lim, drop_en
  );

endinterface

// File: rtl/drop_time_calc_isqrt.sv
// Iterative restoring integer square root, one result bit per step, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch radicand, clear root and remainder
//   step       : consume the top two radicand bits, produce one root bit
//   radicand   : 2*ROOT_W-bit input value
//   root_next  : root including the bit the current step produces; after the
//                final step this equals floor(sqrt(radicand))
module isqrt_iter
  import baggage_drop_pkg::*;
#(
  parameter int unsigned ROOT_W = DEF_TIME_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [2*ROOT_W-1:0]   radicand,
  output logic [ROOT_W-1:0]     root_next
);

  logic [2*ROOT_W-1:0] rad_q;
  logic [ROOT_W-1:0]   root_q;
  logic [ROOT_W+1:0]   rem_q;
  logic [ROOT_W+1:0]   rem_next;
  logic [ROOT_W+3:0]   rem_sh;
  logic [ROOT_W+3:0]   trial;

  // The remainder never exceeds 2*root, so it fits ROOT_W+2 bits once the
  // trial subtraction has been applied; only the shifted copy needs two more.
  always_comb begin
    rem_sh = {rem_q, rad_q[2*ROOT_W-1 -: 2]};
    trial  = {2'b00, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_next  = (ROOT_W+2)'(rem_sh - trial);
      root_next = {root_q[ROOT_W-2:0], 1'b1};
    end else begin
      rem_next  = rem_sh[ROOT_W+1:0];
      root_next = {root_q[ROOT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (load) begin
      rad_q  <= radicand;
      root_q <= '0;
      rem_q  <= '0;
    end else if (step) begin
      rad_q  <= {rad_q[2*ROOT_W-3:0], 2'b00};
      root_q <= root_next;
      rem_q  <= rem_next;
    end
  end

endmodule

// File: rtl/drop_time_calc.sv
// Baggage-drop timing front end: captures four height sensors and the limit
// time, averages the heights, and computes t_act = floor(sqrt(height*SCALE)).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : measurement request, honoured only while idle
//   bus.sensor1..4, bus.t_lim_in : inputs captured together with start
//   bus.busy   : high from LOAD through DONE
//   bus.done   : one-cycle pulse, results newly updated
//   bus.t_act, bus.t_lim, bus.drop_en : registered results, held until next done
module drop_time_calc
  import baggage_drop_pkg::*;
#(
  parameter int unsigned SENS_W = DEF_SENS_W,
  parameter int unsigned TIME_W = DEF_TIME_W,
  parameter int unsigned SCALE  = DEF_SCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  drop_time_calc_if.slave   bus
);

  localparam int unsigned SUM_W = SENS_W + 2;
  localparam int unsigned RAD_W = 2 * TIME_W;
  localparam int unsigned CNT_W = $clog2(TIME_W);

  state_t            state, state_next;
  logic [SENS_W-1:0] s1_q, s2_q, s3_q, s4_q;
  logic [TIME_W-1:0] lim_q;
  logic              nz_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TIME_W-1:0] t_act_q;
  logic [TIME_W-1:0] t_lim_q;
  logic              drop_en_q;

  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_rnd;
  logic [SENS_W-1:0] height;
  logic [RAD_W-1:0]  radicand;
  logic [TIME_W-1:0] root_next;
  logic              sq_load;
  logic              sq_step;
  logic              last_step;

  always_comb begin
    sum      = {2'b00, s1_q} + {2'b00, s2_q} + {2'b00, s3_q} + {2'b00, s4_q};
    sum_rnd  = sum + SUM_W'(2);
    height   = sum_rnd[SUM_W-1:2];
    radicand = RAD_W'(height) * RAD_W'(SCALE);
  end

  assign sq_load   = (state == ST_LOAD);
  assign sq_step   = (state == ST_ROOT);
  assign last_step = sq_step && (cnt_q == '0);

  isqrt_iter #(
    .ROOT_W (TIME_W)
  ) u_isqrt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sq_load),
    .step      (sq_step),
    .radicand  (radicand),
    .root_next (root_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_ROOT;
      ST_ROOT: if (cnt_q == '0) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Results are written on the edge that enters DONE, taking the final root
  // bit straight from the iterator, so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      s4_q      <= '0;
      lim_q     <= '0;
      nz_q      <= 1'b0;
      cnt_q     <= '0;
      t_act_q   <= '0;
      t_lim_q   <= '0;
      drop_en_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        s1_q  <= bus.sensor1;
        s2_q  <= bus.sensor2;
        s3_q  <= bus.sensor3;
        s4_q  <= bus.sensor4;
        lim_q <= bus.t_lim_in;
      end
      if (sq_load) begin
        nz_q  <= (s1_q != '0) && (s2_q != '0) && (s3_q != '0) && (s4_q != '0);
        cnt_q <= CNT_W'(TIME_W - 1);
      end
      if (sq_step) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (last_step) begin
        t_act_q   <= root_next;
        t_lim_q   <= lim_q;
        drop_en_q <= nz_q;
      end
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_DONE);
  assign bus.t_act   = t_act_q;
  assign bus.t_lim   = t_lim_q;
  assign bus.drop_en = drop_en_q;

endmodule

// File: tb/tb_drop_time_calc.sv
// Self-checking bench for drop_time_calc: directed vectors, randomized vectors
// against an arithmetic reference, busy-time input changes, held start and
// asynchronous reset during the root calculation.
module tb_drop_time_calc;
  import baggage_drop_pkg::*;

  localparam int unsigned SW  = 8;
  localparam int unsigned TW  = 16;
  localparam int          LAT = TW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  drop_time_calc_if #(.SENS_W(SW), .TIME_W(TW)) bus ();

  drop_time_calc #(
    .SENS_W (SW),
    .TIME_W (TW),
    .SCALE  (400)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: rounded mean height, then largest r with r*r <= height*400.
  function automatic int unsigned ref_tact(input int unsigned a, b, c, d);
    int unsigned h, r;
    h = (a + b + c + d + 2) / 4;
    r = 0;
    while ((r + 1) * (r + 1) <= h * 400) r++;
    return r;
  endfunction

  // Drives one request and waits (bounded) for done; lat = -1 on timeout.
  task automatic do_measure(input logic [SW-1:0] a, b, c, d, input logic [TW-1:0] lim,
                            output int lat, output logic [TW-1:0] ta, tl, output logic de);
    @(negedge clk);
    bus.sensor1 = a; bus.sensor2 = b; bus.sensor3 = c; bus.sensor4 = d;
    bus.t_lim_in = lim;
    bus.start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    ta = bus.t_act; tl = bus.t_lim; de = bus.drop_en;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.sensor1 = '0; bus.sensor2 = '0; bus.sensor3 = '0; bus.sensor4 = '0;
    bus.t_lim_in = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.drop_en} !== 3'b000 || bus.t_act !== '0 || bus.t_lim !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b t_act=%0d t_lim=%0d drop_en=%b, all required 0",
               bus.busy, bus.done, bus.t_act, bus.t_lim, bus.drop_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [SW-1:0] v [4][4];
    int unsigned   exp_t [4];
    int            lat;
    logic [TW-1:0] ta, tl;
    logic          de;
    v[0] = '{8'd100, 8'd100, 8'd100, 8'd100}; exp_t[0] = 200;
    v[1] = '{8'd10,  8'd20,  8'd30,  8'd40};  exp_t[1] = 100;
    v[2] = '{8'd0,   8'd100, 8'd100, 8'd100}; exp_t[2] = 173;
    v[3] = '{8'd255, 8'd255, 8'd255, 8'd255}; exp_t[3] = 319;
    for (int i = 0; i < 4; i++) begin
      do_measure(v[i][0], v[i][1], v[i][2], v[i][3], TW'(250 + i), lat, ta, tl, de);
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, LAT);
      end
      checks++;
      if (ta !== TW'(exp_t[i])) begin
        errors++;
        $display("FAIL dir%0d_t_act: got %0d required %0d", i, ta, exp_t[i]);
      end
      checks++;
      if (tl !== TW'(250 + i) || de !== (i != 2)) begin
        errors++;
        $display("FAIL dir%0d_lim_en: got t_lim=%0d drop_en=%b required %0d %b",
                 i, tl, de, 250 + i, (i != 2));
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.t_act !== TW'(exp_t[i])) begin
        errors++;
        $display("FAIL dir%0d_after: done=%b busy=%b t_act=%0d required 0 0 %0d",
                 i, bus.done, bus.busy, bus.t_act, exp_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] s [4];
    logic [TW-1:0] lim, ta, tl;
    logic          de, exp_de;
    int            lat;
    int unsigned   exp_t;
    for (int n = 0; n < 24; n++) begin
      for (int j = 0; j < 4; j++)
        s[j] = ($urandom_range(0, 4) == 0) ? 8'd0 : SW'($urandom_range(0, 255));
      lim = TW'($urandom);
      exp_t  = ref_tact(s[0], s[1], s[2], s[3]);
      exp_de = (s[0] != 0) && (s[1] != 0) && (s[2] != 0) && (s[3] != 0);
      do_measure(s[0], s[1], s[2], s[3], lim, lat, ta, tl, de);
      checks++;
      if (lat != LAT || ta !== TW'(exp_t) || tl !== lim || de !== exp_de) begin
        errors++;
        $display("FAIL rand%0d: got lat=%0d t_act=%0d t_lim=%0d drop_en=%b required %0d %0d %0d %b",
                 n, lat, ta, tl, de, LAT, exp_t, lim, exp_de);
      end
    end
  endtask

  task automatic test_busy_changes();
    int unsigned exp_t;
    int          lat;
    int          extra;
    exp_t = ref_tact(40, 80, 120, 160);
    @(negedge clk);
    bus.sensor1 = 8'd40; bus.sensor2 = 8'd80; bus.sensor3 = 8'd120; bus.sensor4 = 8'd160;
    bus.t_lim_in = 16'd777;
    bus.start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_first_cycle: got %b required 1", bus.busy);
        end
      end
      if (k == 6) begin
        bus.sensor1 = 8'd0; bus.sensor2 = 8'd255; bus.sensor3 = 8'd1; bus.sensor4 = 8'd9;
        bus.t_lim_in = 16'd5;
        bus.start = 1'b1;
      end
      if (k == 8) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != LAT || bus.t_act !== TW'(exp_t) || bus.t_lim !== 16'd777 || bus.drop_en !== 1'b1) begin
      errors++;
      $display("FAIL busy_changes: got lat=%0d t_act=%0d t_lim=%0d drop_en=%b required %0d %0d 777 1",
               lat, bus.t_act, bus.t_lim, bus.drop_en, LAT, exp_t);
    end
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_no_queue: got %0d active cycles required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int dones, last, bad_gap, bad_val, width_err;
    @(negedge clk);
    bus.sensor1 = 8'd255; bus.sensor2 = 8'd255; bus.sensor3 = 8'd255; bus.sensor4 = 8'd255;
    bus.t_lim_in = 16'd1000;
    bus.start = 1'b1;
    dones = 0; last = 0; bad_gap = 0; bad_val = 0; width_err = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (dones == 0 && c != LAT) bad_gap++;
        if (dones != 0 && c - last != LAT + 1) bad_gap++;
        if (c - last == 1 && dones != 0) width_err++;
        if (bus.t_act !== 16'd319) bad_val++;
        dones++;
        last = c;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones required 4", dones);
    end
    checks++;
    if (bad_gap != 0 || width_err != 0) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d bad gaps %0d wide pulses required 0 0", bad_gap, width_err);
    end
    checks++;
    if (bad_val != 0) begin
      errors++;
      $display("FAIL b2b_t_act: got %0d wrong results required 0", bad_val);
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int            seen;
    int            lat;
    logic [TW-1:0] ta, tl;
    logic          de;
    @(negedge clk);
    bus.sensor1 = 8'd50; bus.sensor2 = 8'd60; bus.sensor3 = 8'd70; bus.sensor4 = 8'd80;
    bus.t_lim_in = 16'd321;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.drop_en} !== 3'b000 || bus.t_act !== '0 || bus.t_lim !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b t_act=%0d t_lim=%0d drop_en=%b, all required 0",
               bus.busy, bus.done, bus.t_act, bus.t_lim, bus.drop_en);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles required 0", seen);
    end
    do_measure(8'd33, 8'd200, 8'd17, 8'd90, 16'd4242, lat, ta, tl, de);
    checks++;
    if (lat != LAT || ta !== TW'(ref_tact(33, 200, 17, 90)) || tl !== 16'd4242 || de !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_recover: got lat=%0d t_act=%0d t_lim=%0d drop_en=%b required %0d %0d 4242 1",
               lat, ta, tl, de, LAT, ref_tact(33, 200, 17, 90));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_changes();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
